// File: rtl/sram_mem_controller_if.sv
// Bundles the MEM-stage request/response signals and the SRAM pins of the
// data-memory controller. The controller uses the slave view; the MEM stage
// and the SRAM together use the master view.
interface sram_mem_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic               freeze;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
    input  rdata, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
    output rdata, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage load/store into two half-word phases on a
// 16-bit asynchronous SRAM and stalls the pipeline until the access is done.
//
// state | meaning
// IDLE  | waiting for mem_r_en / mem_w_en
// LO    | low half-word phase (WAIT_CYCLES cycles)
// HI    | high half-word phase (WAIT_CYCLES cycles)
// DONE  | ready pulse, rdata valid, back to IDLE
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_mem_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_lo_q, addr_lo_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               op_wr_q, op_wr_d;
  logic [31:0]        rdata_q;

  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;

  logic               req;
  logic               tc;
  logic               start;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] new_lo;
  logic               unused_offset_bits;

  assign req    = bus.mem_r_en | bus.mem_w_en;
  assign tc     = (cnt_q == '0);
  assign start  = (state_q == IDLE) && req;
  // Unsigned subtraction: addresses below BASE_ADDR simply wrap in SRAM space.
  assign offset = bus.addr - BASE_ADDR;
  assign new_lo = {offset[SRAM_AW:2], 1'b0};
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // Next-state and phase-timer logic; the timer counts down to terminal zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = CNT_LOAD;
        end
      end
      LO: begin
        if (tc) begin
          state_d = HI;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HI: begin
        if (tc) state_d = DONE;
        else    cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and SRAM pin values for the state being entered, so the
  // pins are registered in lockstep with the state and never glitch.
  always_comb begin
    addr_lo_d   = start ? new_lo        : addr_lo_q;
    wdata_d     = start ? bus.wdata     : wdata_q;
    op_wr_d     = start ? bus.mem_w_en  : op_wr_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    case (state_d)
      LO: begin
        sram_addr_d = addr_lo_d;
        if (op_wr_d) begin
          dq_out_d = wdata_d[15:0];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end
      end
      HI: begin
        sram_addr_d = {addr_lo_d[SRAM_AW-1:1], 1'b1};
        if (op_wr_d) begin
          dq_out_d = wdata_d[31:16];
          dq_oe_d  = 1'b1;
          we_n_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State, timer, captured request and SRAM pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  // Load data: each half is sampled on the last cycle of its read phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (!op_wr_q && tc) begin
      if (state_q == LO) rdata_q[15:0]  <= bus.sram_dq_in;
      if (state_q == HI) rdata_q[31:16] <= bus.sram_dq_in;
    end
  end

  assign bus.ready       = (state_q == DONE);
  assign bus.freeze      = req & ~bus.ready;
  assign bus.rdata       = rdata_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: one instance at WAIT_CYCLES=2 driven from a vector table,
// plus an instance at WAIT_CYCLES=1 for latency and flush sequences.
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_mem_controller_if #(.SRAM_AW(18)) bus0 ();
  sram_mem_controller_if #(.SRAM_AW(18)) bus1 ();

  sram_mem_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(2))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sram_mem_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // SRAM models: 64 half-words each, indexed by the low address bits.
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  always @(posedge clk) begin
    if (!bus0.sram_we_n && bus0.sram_dq_oe) mem0[bus0.sram_addr[5:0]] <= bus0.sram_dq_out;
  end

  assign bus0.sram_dq_in = mem0[bus0.sram_addr[5:0]];
  assign bus1.sram_dq_in = mem1[bus1.sram_addr[5:0]];

  int n_cmp = 0;
  int n_err = 0;

  logic        cur;
  logic        m_ready, m_freeze, m_we_n;
  logic [31:0] m_rdata;
  assign m_ready  = cur ? bus1.ready     : bus0.ready;
  assign m_freeze = cur ? bus1.freeze    : bus0.freeze;
  assign m_we_n   = cur ? bus1.sram_we_n : bus0.sram_we_n;
  assign m_rdata  = cur ? bus1.rdata     : bus0.rdata;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          lo_idx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    if (cur) begin
      bus1.mem_w_en = wr; bus1.mem_r_en = rd; bus1.addr = a; bus1.wdata = d;
    end else begin
      bus0.mem_w_en = wr; bus0.mem_r_en = rd; bus0.addr = a; bus0.wdata = d;
    end
  endtask

  // Applies one access just after a rising edge and holds it until ready.
  task automatic access(input rec_t v, input int w);
    int fz = 0;
    int wl = 0;
    int rc = -1;
    drive(v.wr, v.rd, v.addr, v.wdata);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_freeze) fz++;
      if (!m_we_n) wl++;
      if (m_ready) begin
        rc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("ready_cycle", 32'(rc), 32'(2*w+1));
    chk("freeze_cycles", 32'(fz), 32'(2*w+1));
    chk("we_low_cycles", 32'(wl), v.wr ? 32'(2*w) : 32'd0);
    chk("rdata", m_rdata, v.exp_rdata);
    if (v.wr && !cur) begin
      chk("sram_lo", {16'h0, mem0[v.lo_idx]},   {16'h0, v.exp_lo});
      chk("sram_hi", {16'h0, mem0[v.lo_idx+1]}, {16'h0, v.exp_hi});
    end
    @(posedge clk); #1;
  endtask

  rec_t vec [8];

  initial begin
    int fz;
    int rc;
    vec[0] = '{1'b1, 1'b0, 32'd1024, 32'h1234_5678, 32'h0000_0000,  0, 16'h5678, 16'h1234};
    vec[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,         32'h1234_5678,  0, 16'h0,    16'h0};
    vec[2] = '{1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'h1234_5678,  2, 16'hBEEF, 16'hDEAD};
    vec[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,         32'hDEAD_BEEF,  0, 16'h0,    16'h0};
    vec[4] = '{1'b0, 1'b1, 32'd1024, 32'h0,         32'h1234_5678,  0, 16'h0,    16'h0};
    vec[5] = '{1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 32'h1234_5678,  4, 16'hF00D, 16'hCAFE};
    vec[6] = '{1'b1, 1'b0, 32'd1020, 32'hA5A5_5A5A, 32'h1234_5678, 62, 16'h5A5A, 16'hA5A5};
    vec[7] = '{1'b0, 1'b1, 32'd1020, 32'h0,         32'hA5A5_5A5A,  0, 16'h0,    16'h0};

    mem1[0] = 16'hBEEF; mem1[1] = 16'h0BAD;
    mem1[2] = 16'h1357; mem1[3] = 16'h2468;

    rst_n = 1'b0;
    cur = 1'b1; drive(1'b0, 1'b0, 32'h0, 32'h0);
    cur = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    chk("rst_sram_addr", 32'(bus0.sram_addr), 32'h0);
    chk("rst_dq_out", {16'h0, bus0.sram_dq_out}, 32'h0);
    chk("rst_dq_oe", 32'(bus0.sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(bus0.sram_we_n), 32'h1);
    chk("rst_rdata", bus0.rdata, 32'h0);
    chk("rst_ready", 32'(bus0.ready), 32'h0);
    chk("rst_freeze", 32'(bus0.freeze), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) access(vec[i], 2);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ready_one_pulse", 32'(bus0.ready), 32'h0);
    chk("idle_we_n", 32'(bus0.sram_we_n), 32'h1);
    @(posedge clk); #1;

    // Reset during the HI phase of a store.
    drive(1'b1, 1'b0, 32'd1040, 32'h1111_2222);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_we_n", 32'(bus0.sram_we_n), 32'h1);
    chk("midrst_oe", 32'(bus0.sram_dq_oe), 32'h0);
    chk("midrst_ready", 32'(bus0.ready), 32'h0);
    chk("midrst_sram_addr", 32'(bus0.sram_addr), 32'h0);
    chk("midrst_rdata", bus0.rdata, 32'h0);
    chk("midrst_partial_lo", {16'h0, mem0[8]}, 32'h0000_2222);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access('{1'b0, 1'b1, 32'd1024, 32'h0, 32'h1234_5678, 0, 16'h0, 16'h0}, 2);

    // WAIT_CYCLES=1 instance: plain load, then a load flushed during LO.
    cur = 1'b1;
    access('{1'b0, 1'b1, 32'd1024, 32'h0, 32'h0BAD_BEEF, 0, 16'h0, 16'h0}, 1);

    drive(1'b0, 1'b1, 32'd1028, 32'h0);
    @(negedge clk);
    chk("flush_freeze_c0", 32'(m_freeze), 32'h1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'd1028, 32'h0);
    fz = 0;
    rc = -1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (m_freeze) fz++;
      if (m_ready) begin
        rc = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("flush_ready_cycle", 32'(rc), 32'd3);
    chk("flush_freeze_cycles", 32'(fz), 32'd0);
    chk("flush_rdata", m_rdata, 32'h2468_1357);
    chk("u1_we_n", 32'(bus1.sram_we_n), 32'h1);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
